// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops, optional multi-cycle shift-add multiply.
// Define ALU_SEQ_MUL_EN to build the multiplier (opcode 10); otherwise opcode 10 behaves as an unused opcode.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_OP,
    input  logic [WIDTH-1:0] Wreg_w,
    input  logic [WIDTH-1:0] Rn_w,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult_w,
    output logic             carryF_w,
    output logic             zeroF_w,
    output logic             ovfF_w
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_DEC = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    logic             done_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             zero_q;
    logic             ovf_q;

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    // INC/DEC reuse the adder/subtractor with a constant 1 as operand B.
    assign opb      = (ALU_OP == OP_INC || ALU_OP == OP_DEC) ? WIDTH'(1) : Rn_w;
    assign sum_ext  = {1'b0, Wreg_w} + {1'b0, opb};
    assign diff_ext = {1'b0, Wreg_w} - {1'b0, opb};

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (ALU_OP)
            OP_ADD, OP_INC: begin
                res_d   = sum_ext[WIDTH-1:0];
                carry_d = sum_ext[WIDTH];
                ovf_d   = (Wreg_w[WIDTH-1] == opb[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != Wreg_w[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                res_d   = diff_ext[WIDTH-1:0];
                carry_d = diff_ext[WIDTH];
                ovf_d   = (Wreg_w[WIDTH-1] != opb[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != Wreg_w[WIDTH-1]);
            end
            OP_AND: res_d = Wreg_w & Rn_w;
            OP_OR:  res_d = Wreg_w | Rn_w;
            OP_XOR: res_d = Wreg_w ^ Rn_w;
            OP_NOT: res_d = ~Wreg_w;
            OP_SHL: begin
                res_d   = {Wreg_w[WIDTH-2:0], 1'b0};
                carry_d = Wreg_w[WIDTH-1];
            end
            OP_SHR: begin
                res_d   = {1'b0, Wreg_w[WIDTH-1:1]};
                carry_d = Wreg_w[0];
            end
            default: begin
                res_d   = '0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam int         CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_step;

    // One partial product per clock: add the shifted multiplicand when the current multiplier LSB is set.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign busy     = (state_q == S_MUL);
`else
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            if (state_q == S_MUL) begin
                // start is deliberately not looked at here: requests while busy are dropped.
                acc_q    <= acc_step;
                mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                cnt_q    <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                    res_q   <= acc_step[WIDTH-1:0];
                    carry_q <= |acc_step[2*WIDTH-1:WIDTH];
                    zero_q  <= (acc_step[WIDTH-1:0] == '0);
                    ovf_q   <= 1'b0;
                end
            end else if (start && ALU_OP == OP_MUL) begin
                state_q  <= S_MUL;
                cnt_q    <= CNT_W'(WIDTH);
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, Wreg_w};
                mplier_q <= Rn_w;
            end else
`endif
            if (start) begin
                done_q  <= 1'b1;
                res_q   <= res_d;
                carry_q <= carry_d;
                zero_q  <= (res_d == '0);
                ovf_q   <= ovf_d;
            end
        end
    end

    assign done        = done_q;
    assign ALUResult_w = res_q;
    assign carryF_w    = carry_q;
    assign zeroF_w     = zero_q;
    assign ovfF_w      = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: WIDTH=8 and WIDTH=16 instances sharing clock and reset.
// Multiply vectors are exercised when ALU_SEQ_MUL_EN is defined, the disabled-opcode path otherwise.
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        s8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, c8, z8, v8;
    logic [7:0]  r8;

    logic        s16 = 1'b0;
    logic [3:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, c16, z16, v16;
    logic [15:0] r16;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .ALU_OP(op8), .Wreg_w(a8), .Rn_w(b8),
        .busy(busy8), .done(done8), .ALUResult_w(r8),
        .carryF_w(c8), .zeroF_w(z8), .ovfF_w(v8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .ALU_OP(op16), .Wreg_w(a16), .Rn_w(b16),
        .busy(busy16), .done(done16), .ALUResult_w(r16),
        .carryF_w(c16), .zeroF_w(z16), .ovfF_w(v16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request on the falling edge, let the rising edge accept it, drop start 1ns later.
    task automatic issue(input bit w16, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (w16) begin
            s16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0];
        end else begin
            s8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end
        @(posedge clk);
        #1;
        s8 = 1'b0;
        s16 = 1'b0;
        if (w16)
            $display("[TB] w16 op=%0d a=%h b=%h -> done=%b busy=%b res=%h C=%b Z=%b V=%b",
                     op, a[15:0], b[15:0], done16, busy16, r16, c16, z16, v16);
        else
            $display("[TB] w8  op=%0d a=%h b=%h -> done=%b busy=%b res=%h C=%b Z=%b V=%b",
                     op, a[7:0], b[7:0], done8, busy8, r8, c8, z8, v8);
    endtask

    task automatic expect8(input string tag, input logic d, input logic [7:0] r,
                           input logic c, input logic z, input logic v);
        check({tag, ".done"}, {31'd0, done8}, {31'd0, d});
        check({tag, ".res"},  {24'd0, r8},    {24'd0, r});
        check({tag, ".C"},    {31'd0, c8},    {31'd0, c});
        check({tag, ".Z"},    {31'd0, z8},    {31'd0, z});
        check({tag, ".V"},    {31'd0, v8},    {31'd0, v});
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect8("rst8", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("rst8.busy", {31'd0, busy8}, 32'd0);
        check("rst16.res", {16'd0, r16}, 32'd0);
        check("rst16.Z", {31'd0, z16}, 32'd1);
        check("rst16.busy", {31'd0, busy16}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        issue(0, 4'd0, 32'hFF, 32'h01);  expect8("add_ff_01", 1, 8'h00, 1, 1, 0);
        @(posedge clk); #1;
        check("add_hold.done", {31'd0, done8}, 32'd0);
        check("add_hold.res", {24'd0, r8}, 32'h00);

        issue(0, 4'd1, 32'h05, 32'h07);  expect8("sub_05_07", 1, 8'hFE, 1, 0, 0);
        issue(0, 4'd1, 32'h80, 32'h01);  expect8("sub_80_01", 1, 8'h7F, 0, 0, 1);
        issue(0, 4'd2, 32'hF0, 32'h3C);  expect8("and",       1, 8'h30, 0, 0, 0);
        issue(0, 4'd3, 32'h12, 32'h21);  expect8("or",        1, 8'h33, 0, 0, 0);
        issue(0, 4'd4, 32'hFF, 32'hFF);  expect8("xor",       1, 8'h00, 0, 1, 0);
        issue(0, 4'd5, 32'h0F, 32'h00);  expect8("not",       1, 8'hF0, 0, 0, 0);
        issue(0, 4'd6, 32'h7F, 32'h00);  expect8("inc_7f",    1, 8'h80, 0, 0, 1);
        issue(0, 4'd7, 32'h00, 32'h00);  expect8("dec_00",    1, 8'hFF, 1, 0, 0);
        issue(0, 4'd8, 32'h81, 32'h00);  expect8("shl_81",    1, 8'h02, 1, 0, 0);
        issue(0, 4'd9, 32'h81, 32'h00);  expect8("shr_81",    1, 8'h40, 1, 0, 0);
        issue(0, 4'd12, 32'hFF, 32'hFF); expect8("op12",      1, 8'h00, 0, 1, 0);

        issue(1, 4'd6, 32'hFFFF, 32'h0);
        check("inc16.done", {31'd0, done16}, 32'd1);
        check("inc16.res", {16'd0, r16}, 32'h0000);
        check("inc16.C", {31'd0, c16}, 32'd1);
        check("inc16.Z", {31'd0, z16}, 32'd1);
        issue(1, 4'd9, 32'h0001, 32'h0);
        check("shr16.res", {16'd0, r16}, 32'h0000);
        check("shr16.C", {31'd0, c16}, 32'd1);

`ifdef ALU_SEQ_MUL_EN
        issue(0, 4'd10, 32'h10, 32'h20);
        check("mul0.busy", {31'd0, busy8}, 32'd1);
        check("mul0.done", {31'd0, done8}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                s8 = 1'b1; op8 = 4'd0; a8 = 8'h01; b8 = 8'h01;
            end
            @(posedge clk);
            #1;
            s8 = 1'b0;
            if (k < 8) begin
                check($sformatf("mul_c%0d.busy", k), {31'd0, busy8}, 32'd1);
                check($sformatf("mul_c%0d.done", k), {31'd0, done8}, 32'd0);
            end
        end
        expect8("mul_10_20", 1, 8'h00, 1, 1, 0);
        check("mul_end.busy", {31'd0, busy8}, 32'd0);
        @(posedge clk); #1;
        check("mul_after.done", {31'd0, done8}, 32'd0);
        check("mul_after.res", {24'd0, r8}, 32'h00);

        issue(0, 4'd10, 32'h0F, 32'h0D);
        repeat (8) @(posedge clk);
        #1;
        expect8("mul_0f_0d", 1, 8'hC3, 0, 0, 0);
`else
        issue(0, 4'd10, 32'h03, 32'h04);
        expect8("op10_off", 1, 8'h00, 0, 1, 0);
        check("op10_off.busy", {31'd0, busy8}, 32'd0);
        @(posedge clk); #1;
        check("op10_off.busy2", {31'd0, busy8}, 32'd0);
`endif

        issue(0, 4'd0, 32'h01, 32'h02); expect8("add_pre", 1, 8'h03, 0, 0, 0);
        issue(0, 4'd10, 32'h0F, 32'h0D);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        expect8("abort_rst", 0, 8'h00, 0, 1, 0);
        check("abort_rst.busy", {31'd0, busy8}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) done_cnt++;
        end
        check("abort.no_done", done_cnt, 32'd0);
        issue(0, 4'd0, 32'h01, 32'h01); expect8("add_post", 1, 8'h02, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width, legal range 4..32.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; accepted only on a rising edge where busy=0.
REQ-005 ALU_OP  input  4  opcode, sampled with start.
REQ-006 Wreg_w  input  WIDTH  operand A, sampled with start.
REQ-007 Rn_w  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while a multi-cycle op is in progress.
REQ-009 done  output  1  one-cycle pulse: results/flags just updated.
REQ-010 ALUResult_w  output  WIDTH  registered result, held until next done.
REQ-011 carryF_w  output  1  registered carry/borrow flag.
REQ-012 zeroF_w  output  1  registered zero flag, (ALUResult_w == 0).
REQ-013 ovfF_w  output  1  registered signed-overflow flag.

Function
REQ-014 States IDLE and MUL; busy = (state == MUL).
REQ-015 Opcodes 0-7: ADD, SUB, AND, OR, XOR, NOT(A), INC(A), DEC(A); single-cycle: result, flags, done=1 after the accepting edge, state stays IDLE.
REQ-016 ADD/INC: WIDTH+1-bit sum, carryF_w = bit WIDTH; SUB/DEC: zero-extended difference, carryF_w = borrow (bit WIDTH).
REQ-017 ovfF_w = two's-complement overflow for ADD, SUB, INC, DEC; 0 for all other ops.
REQ-018 Logic ops (AND, OR, XOR, NOT): carryF_w=0.
REQ-019 Opcode 8 SHL: A<<1, carryF_w = A[WIDTH-1]; opcode 9 SHR (logical): A>>1, carryF_w = A[0]; single-cycle.
REQ-020 Opcode 10 MUL (when enabled): unsigned shift-add, one partial-product step per clock; accepting edge loads operands, counter=WIDTH, enters MUL.
REQ-021 MUL: after exactly WIDTH further edges outputs update, done=1, state returns to IDLE; latency from accepting edge to done = WIDTH cycles.
REQ-022 MUL result: ALUResult_w = low WIDTH bits of product; carryF_w = 1 iff any high WIDTH bits nonzero.
REQ-023 Opcodes 11-15, and 10 when MUL disabled: ALUResult_w=0, carryF_w=0, ovfF_w=0, zeroF_w=1, single-cycle done.
REQ-024 start while busy=1: ignored, no effect on operands, counter or outputs.
REQ-025 Back-to-back: start may be accepted on the same edge done rises (IDLE after single-cycle op); each accepted op yields exactly one done.
REQ-026 Outputs are never combinationally dependent on inputs; ALUResult_w and flags change only on edges where done goes high.

Reset
REQ-027 rst_n=0 forces immediately: state IDLE, busy=0, done=0, ALUResult_w=0, carryF_w=0, zeroF_w=1, ovfF_w=0, counter=0.
REQ-028 Reset during MUL aborts the op; no done is produced for it.
REQ-029 First start accepted on the first rising edge with rst_n=1.

Configuration
REQ-030 Macro ALU_SEQ_MUL_EN: defined -> MUL datapath, counter and MUL state built, opcode 10 per REQ-020..022.
REQ-031 Not defined -> no multiplier logic, busy tied 0, opcode 10 handled per REQ-023.

Verification
REQ-032 WIDTH=8, ADD A=8'hFF B=8'h01 -> next cycle done=1, result 8'h00, C=1, Z=1, V=0.
REQ-033 WIDTH=8, SUB A=8'h05 B=8'h07 -> result 8'hFE, C=1, Z=0; SUB A=8'h80 B=8'h01 -> 8'h7F, V=1.
REQ-034 WIDTH=8, MUL A=8'h10 B=8'h20 (MUL_EN) -> busy 8 cycles, done after 8th edge, result 8'h00, C=1, Z=1; extra start at cycle 3 ignored.
REQ-035 WIDTH=8, MUL A=8'h0F B=8'h0D, rst_n low at cycle 4 -> all outputs reset values, no done; next ADD 8'h01+8'h01 -> 8'h02 one cycle later.
REQ-036 WIDTH=16, INC A=16'hFFFF -> result 16'h0000, C=1, Z=1; SHR A=16'h0001 -> 16'h0000, C=1.
REQ-037 Without ALU_SEQ_MUL_EN, opcode 10 A=8'h03 B=8'h04 -> single-cycle done, result 8'h00, Z=1, busy stays 0.
